// File: rtl/bin_stim_pkg.sv
// Shared encodings and LFSR step for the bin_counter stimulus sequencer.
// The state values are visible on the phase output, so they are fixed here.
package bin_stim_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_UP   = 3'd2;
    localparam logic [2:0] ST_DOWN = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;
    localparam logic [2:0] ST_RAND = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_UP   = ST_UP,
        S_DOWN = ST_DOWN,
        S_HOLD = ST_HOLD,
        S_RAND = ST_RAND,
        S_DONE = ST_DONE
    } state_e;

    // Galois form, right shift: fold the taps in when a 1 falls off the end.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous reseed and a per-cycle advance enable.
// Reset and reload both return to the seed; reload beats advance.
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        reload_i,
    input  logic        advance_i,
    input  logic [15:0] seed_i,
    output logic [15:0] value_o
);
    import bin_stim_pkg::*;

    logic [15:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (reload_i) begin
            value_d = seed_i;
        end else if (advance_i) begin
            value_d = lfsr_step(value_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= seed_i;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/bin_stim_gen.sv
// Stimulus sequencer for bin_counter: LOAD, UP, DOWN, HOLD, then LFSR-driven RAND, then DONE.
// Every output is a flop fed from the next state, so outputs match the phase they report.
module bin_stim_gen
    import bin_stim_pkg::*;
#(
    parameter int unsigned  N           = 3,
    parameter logic [N-1:0] LOAD_VAL    = N'(5),
    parameter int unsigned  UP_CYCLES   = 4,
    parameter int unsigned  DOWN_CYCLES = 2,
    parameter int unsigned  HOLD_CYCLES = 2,
    parameter int unsigned  RAND_CYCLES = 8,
    parameter logic [15:0]  SEED        = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         abort_i,
    output logic         load_o,
    output logic         a_o,
    output logic         b_o,
    output logic [N-1:0] d_o,
    output logic [2:0]   phase_o,
    output logic         busy_o,
    output logic         done_o
);

    if (N == 0 || N > 11) begin : g_bad_width
        $error("bin_stim_gen: N must be in 1..11");
    end
    if (UP_CYCLES > 65535 || DOWN_CYCLES > 65535 ||
        HOLD_CYCLES > 65535 || RAND_CYCLES > 65535) begin : g_bad_len
        $error("bin_stim_gen: phase lengths must fit the 16-bit phase counter");
    end

    // An all-zero seed would freeze the LFSR.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Successor of each phase with empty phases folded out, so no dead cycle appears.
    localparam state_e AFTER_HOLD = (RAND_CYCLES != 0) ? S_RAND : S_DONE;
    localparam state_e AFTER_DOWN = (HOLD_CYCLES != 0) ? S_HOLD : AFTER_HOLD;
    localparam state_e AFTER_UP   = (DOWN_CYCLES != 0) ? S_DOWN : AFTER_DOWN;
    localparam state_e AFTER_LOAD = (UP_CYCLES   != 0) ? S_UP   : AFTER_UP;

    state_e       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [15:0]  len;
    logic         last;
    logic [15:0]  lfsr;
    logic         lfsr_adv;

    logic         load_q, load_d;
    logic         a_q, a_d;
    logic         b_q, b_d;
    logic [N-1:0] d_q, d_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    lfsr16 u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .reload_i  (abort_i),
        .advance_i (lfsr_adv),
        .seed_i    (SEED_EFF),
        .value_o   (lfsr)
    );

    always_comb begin
        len = 16'd1;
        case (state_q)
            S_UP:    len = 16'(UP_CYCLES);
            S_DOWN:  len = 16'(DOWN_CYCLES);
            S_HOLD:  len = 16'(HOLD_CYCLES);
            S_RAND:  len = 16'(RAND_CYCLES);
            default: len = 16'd1;
        endcase
    end

    assign last = (cnt_q == len - 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_i) state_d = S_LOAD;
            S_LOAD:         state_d = AFTER_LOAD;
            S_UP:           if (last) state_d = AFTER_UP;
            S_DOWN:         if (last) state_d = AFTER_DOWN;
            S_HOLD:         if (last) state_d = AFTER_HOLD;
            S_RAND:         if (last) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
        end

        // Counter restarts on every phase entry and parks at zero while idle or done.
        cnt_d = cnt_q + 16'd1;
        if (state_d != state_q || state_d == S_IDLE || state_d == S_DONE) begin
            cnt_d = 16'd0;
        end
    end

    always_comb begin
        load_d   = 1'b0;
        a_d      = 1'b0;
        b_d      = 1'b0;
        d_d      = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        lfsr_adv = 1'b0;
        case (state_d)
            S_LOAD: begin
                load_d = 1'b1;
                d_d    = LOAD_VAL;
            end
            S_UP: begin
                a_d = 1'b1;
                b_d = 1'b1;
            end
            S_DOWN: a_d = 1'b1;
            S_HOLD: ;
            S_RAND: begin
                // Outputs take the current value while the LFSR steps on the same edge.
                load_d   = (lfsr[2:0] == 3'b000);
                a_d      = lfsr[3];
                b_d      = lfsr[4];
                d_d      = lfsr[N+4:5];
                lfsr_adv = 1'b1;
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            load_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Upper LFSR bits only feed d when N is wide.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr;

    assign load_o  = load_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign d_o     = d_q;
    assign phase_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
